// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves register operands through MEM/WB forwarding, muxes ALU sources
// and registers them behind a single-entry valid/ready pipeline slot.
module alu_operand_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sel1,
    input  logic [1:0]        sel2,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [WIDTH-1:0]  imm,
    input  logic [WIDTH-1:0]  pc,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [WIDTH-1:0]  fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [WIDTH-1:0]  fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  src1,
    output logic [WIDTH-1:0]  src2,
    output logic [WIDTH-1:0]  store_data,
    output logic              sel_err
);

    localparam logic [1:0] SEL1_RS1  = 2'd0;
    localparam logic [1:0] SEL1_PC   = 2'd1;
    localparam logic [1:0] SEL1_ZERO = 2'd2;
    localparam logic [1:0] SEL2_RS2  = 2'd0;
    localparam logic [1:0] SEL2_IMM  = 2'd1;
    localparam logic [1:0] SEL2_CONST = 2'd2;
    localparam logic [1:0] SEL_ILL   = 2'd3;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [WIDTH-1:0] rs1_val, rs2_val;
    logic             capture;

    // x0 is hardwired; the younger MEM result wins over WB when both target the same register.
    function automatic logic [WIDTH-1:0] resolve(input logic [REG_AW-1:0] addr,
                                                 input logic [WIDTH-1:0]  rf_data);
        if (addr == '0) begin
            return '0;
        end else if (fwd_mem_we && fwd_mem_rd == addr) begin
            return fwd_mem_data;
        end else if (fwd_wb_we && fwd_wb_rd == addr) begin
            return fwd_wb_data;
        end
        return rf_data;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        rs1_val = resolve(rs1_addr, rs1_data);
        rs2_val = resolve(rs2_addr, rs2_data);

        unique case (sel1)
            SEL1_RS1:  src1_d = rs1_val;
            SEL1_PC:   src1_d = pc;
            SEL1_ZERO: src1_d = '0;
            default:   src1_d = '0;
        endcase

        unique case (sel2)
            SEL2_RS2:   src2_d = rs2_val;
            SEL2_IMM:   src2_d = imm;
            SEL2_CONST: src2_d = STEP;
            default:    src2_d = '0;
        endcase

        store_d   = rs2_val;
        sel_err_d = sel_err_q || (capture && (sel1 == SEL_ILL || sel2 == SEL_ILL));

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = out_valid_q && !out_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            store_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            if (capture) begin
                src1_q  <= src1_d;
                src2_q  <= src2_d;
                store_q <= store_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign sel_err    = sel_err_q;
    assign src1       = src1_q;
    assign src2       = src2_q;
    assign store_data = store_q;

endmodule
